// File: rtl/lab2_dg_disp_pkg.sv
// Shared types and helpers for the multiplexed 7-segment display scheduler.
package lab2_dg_disp_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } disp_state_t;

  typedef logic [3:0] nibble_t;

  // Larger of two unsigned values.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lab2_dg_term_cnt.sv
// Loadable terminal counter: counts 0..limit while enabled and pulses done_c
// on the terminal count, wrapping back to zero on the same edge.
module lab2_dg_term_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] cnt,
  output logic         done_c
);

  assign done_c = en && (cnt == limit);

  // Count register; clear and terminal count both return to zero.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (done_c) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lab2_dg_disp_sched.sv
// Time-multiplexing scheduler for N common-anode digits sharing one 7-segment
// decoder. Snapshots the digit vector once per frame, then walks the digits
// with a blanking gap before each one. Outputs are registered.
// Optional feature: define LEADING_ZERO_BLANK_EN to keep leading zero digits dark.
module lab2_dg_disp_sched
  import lab2_dg_disp_pkg::*;
#(
  parameter int unsigned N_DIGITS     = 2,
  parameter int unsigned DWELL_CYCLES = 24000,
  parameter int unsigned BLANK_CYCLES = 240
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic                  en,
  output logic [3:0]            mux,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  frame_start
);

  localparam int unsigned CNT_W = width_of(max_u(DWELL_CYCLES, BLANK_CYCLES));
  localparam int unsigned IDX_W = width_of(N_DIGITS);

  disp_state_t          state, state_next;
  logic [IDX_W-1:0]     idx, idx_next;
  nibble_t              shadow [N_DIGITS];
  logic                 en_q;
  logic                 load;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic                 cnt_done;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_limit;
  logic                 suppress;
  logic [3:0]           mux_d;
  logic [N_DIGITS-1:0]  anode_d;

  assign cnt_limit = (state == S_ON) ? CNT_W'(DWELL_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1);

  // One counter shared by the blank gap and the dwell period.
  lab2_dg_term_cnt #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .en     (cnt_en),
    .limit  (cnt_limit),
    .cnt    (cnt),
    .done_c (cnt_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic: load snapshot, then blank/on per digit, then reload.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    case (state)
      S_LOAD: begin
        load       = 1'b1;
        cnt_clr    = 1'b1;
        idx_next   = '0;
        state_next = S_BLANK;
      end
      S_BLANK: begin
        cnt_en = 1'b1;
        if (cnt_done) state_next = S_ON;
      end
      S_ON: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          if (idx == IDX_W'(N_DIGITS - 1)) begin
            idx_next   = '0;
            state_next = S_LOAD;
          end else begin
            idx_next   = idx + IDX_W'(1);
            state_next = S_BLANK;
          end
        end
      end
      default: begin
        idx_next   = '0;
        state_next = S_LOAD;
      end
    endcase
  end

  // Snapshot of the digit vector and the enable pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) shadow[i] <= '0;
    end else begin
      en_q <= en;
      if (load) begin
        for (int i = 0; i < int'(N_DIGITS); i++) shadow[i] <= digits[4*i +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit above digit 0 stays dark when it and every higher digit are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    suppress   = 1'b0;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      zero_above = zero_above && (shadow[i] == 4'h0);
      if (idx == IDX_W'(i)) suppress = zero_above;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Output decode from registered state: selected nibble and one-cold anode.
  always_comb begin
    mux_d   = '0;
    anode_d = '1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        mux_d = shadow[i];
        if ((state == S_ON) && en_q && !suppress) anode_d[i] = 1'b0;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux         <= '0;
      anode       <= '1;
      frame_start <= 1'b0;
    end else begin
      mux         <= mux_d;
      anode       <= anode_d;
      frame_start <= (state == S_LOAD);
    end
  end

endmodule

// File: tb/tb_lab2_dg_disp_sched.sv
// Directed bench for lab2_dg_disp_sched: a 2-digit and a 4-digit instance,
// DWELL=4, BLANK=2. Honors LEADING_ZERO_BLANK_EN when defined.
module tb_lab2_dg_disp_sched;

  localparam int DW = 4;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  digits2;
  logic [15:0] digits4;
  logic [3:0]  mux2, mux4;
  logic [1:0]  anode2;
  logic [3:0]  anode4;
  logic        fs2, fs4;

  int total  = 0;
  int passed = 0;

  lab2_dg_disp_sched #(.N_DIGITS(2), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut2 (
    .clk(clk), .reset(reset), .digits(digits2), .en(en),
    .mux(mux2), .anode(anode2), .frame_start(fs2)
  );

  lab2_dg_disp_sched #(.N_DIGITS(4), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut4 (
    .clk(clk), .reset(reset), .digits(digits4), .en(en),
    .mux(mux4), .anode(anode4), .frame_start(fs4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int c, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, c, obs, exp);
  endtask

  // Reference model of one frame position p for an nd-digit display.
  task automatic model(input int nd, input int p, input logic [15:0] sh, input logic [3:0] prev,
                       input logic en_on, output logic [3:0] ea, output logic [3:0] em,
                       output logic ef);
    logic [3:0] mask;
    int q, d, r;
    logic sup;
    mask = 4'((1 << nd) - 1);
    ef = 1'b0;
    ea = mask;
    if (p == 0) begin
      ef = 1'b1;
      em = prev;
    end else begin
      q  = p - 1;
      d  = q / (BL + DW);
      r  = q % (BL + DW);
      em = sh[4*d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      sup = (d > 0) && ((sh >> (4*d)) == 16'h0);
`else
      sup = 1'b0;
`endif
      if (r >= BL && en_on && !sup) ea = mask & ~4'(1 << d);
    end
  endtask

  // Run ncyc cycles after reset release, checking every output every cycle.
  task automatic run_seq(input int nd, input int ncyc, input int chg_at, input logic [7:0] chg_val);
    logic [15:0] sh, cur;
    logic [3:0]  prev, ea, em, oa, om, mask;
    logic        ef, of;
    int p, fl;
    sh   = '0;
    fl   = 1 + nd * (BL + DW);
    mask = 4'((1 << nd) - 1);
    for (int c = 0; c < ncyc; c++) begin
      cur = (nd == 2) ? {8'h00, digits2} : digits4;
      tick();
      p    = c % fl;
      prev = sh[3:0];
      if (p == 0) sh = cur;
      model(nd, p, sh, prev, en, ea, em, ef);
      if (nd == 2) begin
        oa = {2'b00, anode2}; om = mux2; of = fs2;
      end else begin
        oa = anode4; om = mux4; of = fs4;
      end
      chk($sformatf("anode_n%0d", nd), c, {12'h0, oa}, {12'h0, ea});
      chk($sformatf("mux_n%0d", nd), c, {12'h0, om}, {12'h0, em});
      chk($sformatf("frame_start_n%0d", nd), c, {15'h0, of}, {15'h0, ef});
      chk($sformatf("one_low_n%0d", nd), c, 16'($countones(~oa & mask) <= 1), 16'h1);
      if (c == chg_at) digits2 = chg_val;
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    repeat (3) tick();
    chk({tag, "_anode2"}, -1, {14'h0, anode2}, 16'h0003);
    chk({tag, "_mux2"}, -1, {12'h0, mux2}, 16'h0000);
    chk({tag, "_fs2"}, -1, {15'h0, fs2}, 16'h0000);
    chk({tag, "_anode4"}, -1, {12'h0, anode4}, 16'h000F);
    chk({tag, "_fs4"}, -1, {15'h0, fs4}, 16'h0000);
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    en      = 1'b1;
    digits2 = 8'hA5;
    digits4 = 16'h1234;

    // Reset, basic frame, then snapshot isolation: digits change at cycle 5.
    do_reset("rst1");
    run_seq(2, 27, 5, 8'h3C);

    // Display disabled: anodes stay off while sequencing continues.
    digits2 = 8'hA5;
    reset   = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    reset = 1'b0;
    run_seq(2, 27, -1, 8'h00);

    // Reset in the middle of the first ON period, then a clean restart.
    en = 1'b1;
    do_reset("rst4");
    run_seq(2, 5, -1, 8'h00);
    reset = 1'b1;
    tick();
    chk("midrst_anode", 4, {14'h0, anode2}, 16'h0003);
    chk("midrst_mux", 4, {12'h0, mux2}, 16'h0000);
    chk("midrst_fs", 4, {15'h0, fs2}, 16'h0000);
    tick();
    reset = 1'b0;
    run_seq(2, 14, -1, 8'h00);

    // Leading-zero cases: 07 then 00.
    digits2 = 8'h07;
    do_reset("rst5a");
    run_seq(2, 27, -1, 8'h00);
    digits2 = 8'h00;
    do_reset("rst5b");
    run_seq(2, 27, -1, 8'h00);

    // Four-digit wrap.
    digits4 = 16'h1234;
    do_reset("rst6");
    run_seq(4, 51, -1, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
